midi_note_parser: RTL

Byte-level MIDI message parser that sits directly upstream of the synthesizer top: it consumes received MIDI bytes from the serial receiver and produces the 16-bit note command word (start/stop bit, 7-bit note, 8-bit velocity) driven onto the synthesizer's `i_data` input. It handles Note On, Note Off, running status, the All Notes Off controller and real-time bytes. It discards every other message cleanly without losing byte alignment.

---
 rtl/midi_note_parser_if.sv | 21 ++
 rtl/midi_note_parser.sv | 98 +++++++++
 2 files changed

// File: rtl/midi_note_parser_if.sv
// rtl/midi_note_parser_if.sv - byte-in / command-word-out bundle for the MIDI note parser
interface midi_note_parser_if;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic [15:0] o_data;
  logic        o_valid;

  modport master (
    output i_byte,
    output i_byte_valid,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  i_byte,
    input  i_byte_valid,
    output o_data,
    output o_valid
  );
endinterface

// File: rtl/midi_note_parser.sv
// rtl/midi_note_parser.sv - MIDI byte parser producing start/stop note command words
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter logic       OMNI    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  midi_note_parser_if.slave bus
);
  localparam logic [15:0] STOP_ALL = 16'h7F00;

  typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_e;
  typedef enum logic [2:0] {NOTE_ON, NOTE_OFF, CC, SKIP1, SKIP2} kind_e;

  state_e      state_q;
  kind_e       kind_q;
  logic [6:0]  d1_q;
  logic [15:0] data_q;
  logic        valid_q;

  logic [7:0]  byte_w;
  logic        ch_ok;
  logic        is_sys;
  logic        is_status;
  logic        vel_nz;
  logic        note_ok;
  kind_e       status_kind;

  assign byte_w    = bus.i_byte;
  assign ch_ok     = OMNI || (byte_w[3:0] == CHANNEL);
  assign is_sys    = (byte_w[7:3] == 5'b11110);
  assign is_status = byte_w[7] && (byte_w[7:4] != 4'hF);
  assign vel_nz    = |byte_w[6:0];
  assign note_ok   = (d1_q != 7'h7F);

  // Off-channel note/controller messages still need two data bytes, so they become SKIP2.
  always_comb begin
    status_kind = SKIP2;
    case (byte_w[7:4])
      4'h8:       status_kind = ch_ok ? NOTE_OFF : SKIP2;
      4'h9:       status_kind = ch_ok ? NOTE_ON  : SKIP2;
      4'hB:       status_kind = ch_ok ? CC       : SKIP2;
      4'hC, 4'hD: status_kind = SKIP1;
      default:    status_kind = SKIP2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= SKIP2;
      d1_q    <= 7'd0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.i_byte_valid) begin
        if (is_sys) begin
          state_q <= IDLE;
        end else if (is_status) begin
          state_q <= DATA1;
          kind_q  <= status_kind;
        end else if (!byte_w[7]) begin
          case (state_q)
            DATA1: begin
              if (kind_q != SKIP1) begin
                d1_q    <= byte_w[6:0];
                state_q <= DATA2;
              end
            end
            DATA2: begin
              state_q <= DATA1;
              case (kind_q)
                NOTE_ON, NOTE_OFF: begin
                  if (note_ok) begin
                    data_q  <= {(kind_q == NOTE_ON) && vel_nz, d1_q, byte_w};
                    valid_q <= 1'b1;
                  end
                end
                CC: begin
                  if (d1_q == 7'd123 || d1_q == 7'd120) begin
                    data_q  <= STOP_ALL;
                    valid_q <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
endmodule
